// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage pipeline: load/store unit over a req/ack data bus
// with alignment, sign extension, timeout abort and the MEM/WB pipeline register.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        ResultSrcM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        ResultSrcW,
  output logic        RegWriteW
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic             w_memOp;
  logic             w_isByte;
  logic             w_isHalf;
  logic             w_unsigned;
  logic             w_misaligned;
  logic             w_issue;
  logic             w_timeout;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_loadData;

  logic [CNT_W-1:0] r_cnt;
  logic             r_aborted;
  logic [31:0]      r_loadData;

  // Funct3 codes other than B/H/BU/HU fall into the word path.
  assign w_memOp      = ResultSrcM | MemWriteM;
  assign w_isByte     = (Funct3M[1:0] == 2'b00);
  assign w_isHalf     = (Funct3M[1:0] == 2'b01);
  assign w_unsigned   = Funct3M[2];
  assign w_misaligned = w_isHalf ? ALUResultM[0]
                                 : (!w_isByte && (ALUResultM[1:0] != 2'b00));
  assign w_issue      = w_memOp && !w_misaligned;
  assign w_timeout    = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_be    = 4'hF;
    w_wdata = WriteDataM;
    if (w_isByte) begin
      w_be    = 4'b0001 << ALUResultM[1:0];
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_isHalf) begin
      w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
      w_wdata = {2{WriteDataM[15:0]}};
    end
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (ALUResultM[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half     = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_loadData = dmem_rdata;
    if (w_isByte) begin
      w_loadData = w_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (w_isHalf) begin
      w_loadData = w_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    StallM      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_nextState = BUSY;
          StallM      = 1'b1;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (dmem_ack || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The EX/MEM inputs stay frozen by StallM until DONE, so DONE writes back
  // the same instruction that was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'b0;
      dmem_wdata <= 32'b0;
      dmem_be    <= 4'b0;
      MisalignM  <= 1'b0;
      BusErrM    <= 1'b0;
      ALUResultW <= 32'b0;
      ReadDataW  <= 32'b0;
      RdW        <= 5'b0;
      PCPlus4W   <= 32'b0;
      ResultSrcW <= 1'b0;
      RegWriteW  <= 1'b0;
      r_cnt      <= '0;
      r_aborted  <= 1'b0;
      r_loadData <= 32'b0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_cnt      <= '0;
            r_aborted  <= 1'b0;
            r_loadData <= 32'b0;
            RegWriteW  <= 1'b0;
          end else begin
            MisalignM  <= w_memOp;
            ALUResultW <= ALUResultM;
            ReadDataW  <= 32'b0;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ResultSrcW <= ResultSrcM;
            RegWriteW  <= RegWriteM & ~w_memOp;
          end
        end
        BUSY: begin
          RegWriteW <= 1'b0;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (ResultSrcM) begin
              r_loadData <= w_loadData;
            end
          end else if (w_timeout) begin
            dmem_req  <= 1'b0;
            BusErrM   <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          ALUResultW <= ALUResultM;
          ReadDataW  <= r_loadData;
          RdW        <= RdM;
          PCPlus4W   <= PCPlus4M;
          ResultSrcW <= ResultSrcM;
          RegWriteW  <= RegWriteM & ~r_aborted;
        end
        default: begin
          RegWriteW <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and performs loads and stores over a variable-latency data-memory request/acknowledge bus. Handles byte, half and word alignment and sign extension, and stalls the front of the pipeline while an access is outstanding. Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before abort; 0 disables timeout
CNT_W, 5, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
ALUResultM  input  32  effective address / ALU result
WriteDataM  input  32  store data
RdM  input  5  destination register
PCPlus4M  input  32  PC+4
ResultSrcM  input  1  1 = load
RegWriteM  input  1  register write enable
MemWriteM  input  1  1 = store
Funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write
dmem_addr  output  32  word address {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  access complete; rdata valid this cycle for reads
dmem_rdata  input  32  read word
StallM  output  1  combinational; holds IF/ID/EX and the EX/MEM register
MisalignM  output  1  1-cycle pulse on misaligned access
BusErrM  output  1  1-cycle pulse on timeout abort
ALUResultW  output  32  MEM/WB ALU result
ReadDataW  output  32  MEM/WB extended load data
RdW  output  5  MEM/WB destination register
PCPlus4W  output  32  MEM/WB PC+4
ResultSrcW  output  1  MEM/WB load flag
RegWriteW  output  1  MEM/WB write enable

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE immediately. dmem_req=0. All registered outputs and the counter are 0. Reset during BUSY abandons the access; no completion is produced.
- MemOp = ResultSrcM | MemWriteM. Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, MemOp, aligned:
  - Go to BUSY; set dmem_req<=1.
  - Register dmem_we=MemWriteM, dmem_addr, dmem_be and dmem_wdata.
  - StallM=1.
- IDLE, MemOp, misaligned:
  - No request; stay in IDLE; StallM=0.
  - MisalignM<=1 for one cycle.
  - MEM/WB captures the instruction with RegWriteW<=0.
- IDLE, no MemOp: StallM=0; MEM/WB captures inputs; ReadDataW<=0.
- BUSY:
  - StallM=1; dmem_req and all request fields are held stable.
  - On dmem_ack=1: dmem_req<=0. For loads, latch the extracted data. Go to DONE.
  - Ack in the first BUSY cycle is legal. dmem_ack while dmem_req=0 is ignored.
- Timeout (TIMEOUT>0): the counter increments on each BUSY cycle without ack. When it reaches TIMEOUT:
  - dmem_req<=0; BusErrM pulses.
  - Go to DONE with the completion marked aborted, so RegWriteW<=0.
- DONE:
  - StallM=0; MEM/WB captures the instruction, with ReadDataW = latched data.
  - Return to IDLE. The held EX/MEM contents are not re-issued.
- Best-case memory op: 2 stall cycles; the MEM/WB update happens at the end of the 3rd cycle.
- While StallM=1, MEM/WB captures a bubble: RegWriteW<=0, other W fields unchanged.
- Byte enables and store data:
  - B: be=4'b0001<<addr[1:0]; wdata={4{WriteDataM[7:0]}}.
  - H: be=4'b0011<<{addr[1],1'b0}; wdata={2{WriteDataM[15:0]}}.
  - W: be=4'hF; wdata=WriteDataM.
- Load extraction: select the byte/half lane by addr[1:0]. B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
- Stores complete with RegWriteW = RegWriteM (normally 0).

Test Plan:
- ALU op (RegWriteM=1, RdM=5, ALUResultM=0x1234, no MemOp) -> next edge: RegWriteW=1, RdW=5, ALUResultW=0x1234; StallM never asserts.
- LB at addr 0x103, dmem_rdata=0x80FF_FF7F, ack in first BUSY cycle -> StallM high for 2 cycles; dmem_addr=0x100; ReadDataW=0xFFFF_FF80; RegWriteW=1.
- SH at addr 0x202, WriteDataM=0xDEAD_BEEF, ack after 3 BUSY cycles -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF; dmem_req and fields stable for 3 cycles; StallM for 4 cycles; a single completion.
- LW at addr 0x101 -> no dmem_req; MisalignM pulses 1 cycle; RegWriteW=0; no stall.
- LW with no ack, TIMEOUT=16 -> dmem_req drops after 16 BUSY cycles; BusErrM pulses; RegWriteW=0; FSM returns to IDLE.
- rst=0 asserted mid-BUSY -> dmem_req=0 and all W outputs 0 with no clock edge; after release, a new LW completes normally.
